// File: rtl/sfp_vec_scalar_op_pipe_pkg.sv
// Shared types for the signed fixed-point vector-by-scalar unit: op encoding and word-width helper.
package sfp_pkg;

    typedef enum logic [1:0] {
        OP_ADD  = 2'd0,
        OP_SUB  = 2'd1,
        OP_RSUB = 2'd2,
        OP_MUL  = 2'd3
    } sfp_op_e;

    function automatic int sfp_width(input int iw, input int qw);
        return iw + qw;
    endfunction

endpackage

// File: rtl/sfp_vec_scalar_op_pipe_lane_op.sv
// One combinational lane: res = a OP s in signed Q(W-QW).QW with overflow detect.
// SFP_VEC_SAT_EN selects clamping on overflow; otherwise the low W bits wrap.
module sfp_lane_op
    import sfp_pkg::*;
#(
    parameter int W  = 32,
    parameter int QW = 16
) (
    input  sfp_op_e        op,
    input  logic [W-1:0]   a,
    input  logic [W-1:0]   s,
    output logic [W-1:0]   res,
    output logic           ovf
);

`ifdef SFP_VEC_SAT_EN
    localparam logic [W-1:0] SFP_MAX = {1'b0, {(W-1){1'b1}}};
    localparam logic [W-1:0] SFP_MIN = {1'b1, {(W-1){1'b0}}};
    logic                    neg;
`endif

    logic signed [W:0]     ax;
    logic signed [W:0]     sx;
    logic signed [W:0]     sum;
    logic signed [2*W-1:0] prod;
    logic signed [2*W-1:0] prod_shr;
    logic [W-1:0]          wrap;

    // NOTE: every variable is given a value on every path through this block, so no latch is inferred.
    always_comb begin
        ax       = {a[W-1], a};
        sx       = {s[W-1], s};
        // Operands widened to 2W so the low 2W bits of the product are the exact signed product.
        prod     = $signed({{W{a[W-1]}}, a}) * $signed({{W{s[W-1]}}, s});
        prod_shr = prod >>> QW;

        case (op)
            OP_ADD:  sum = ax + sx;
            OP_SUB:  sum = ax - sx;
            OP_RSUB: sum = sx - ax;
            default: sum = '0;
        endcase

        if (op == OP_MUL) begin
            wrap = prod_shr[W-1:0];
            // In range only when the bits above the result are a pure sign extension.
            ovf  = !((&prod_shr[2*W-1:W-1]) || !(|prod_shr[2*W-1:W-1]));
        end else begin
            wrap = sum[W-1:0];
            ovf  = sum[W] ^ sum[W-1];
        end

`ifdef SFP_VEC_SAT_EN
        neg = (op == OP_MUL) ? prod_shr[2*W-1] : sum[W];
        res = ovf ? (neg ? SFP_MIN : SFP_MAX) : wrap;
`else
        res = wrap;
`endif
    end

endmodule

// File: rtl/sfp_vec_scalar_op_pipe.sv
// Two-stage pipelined N-lane vector-by-scalar fixed-point unit with valid/ready and whole-pipe stall.
// Optional build macro: SFP_VEC_SAT_EN (saturate overflowing lanes instead of wrapping).
module sfp_vec_scalar_op_pipe
    import sfp_pkg::*;
#(
    parameter  int N  = 3,
    parameter  int IW = 16,
    parameter  int QW = 16,
    localparam int W  = sfp_width(IW, QW)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  sfp_op_e             in_op,
    input  logic [N-1:0][W-1:0] in_a,
    input  logic [W-1:0]        in_s,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [N-1:0][W-1:0] out_o,
    output logic [N-1:0]        out_ovf
);

    logic                en;
    logic                s1_valid;
    sfp_op_e             s1_op;
    logic [N-1:0][W-1:0] s1_a;
    logic [W-1:0]        s1_s;
    logic [N-1:0][W-1:0] lane_res;
    logic [N-1:0]        lane_ovf;

    // Single advance signal: the pipe moves only when the output slot is free or being drained.
    assign en       = !out_valid || out_ready;
    assign in_ready = en;

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid  <= 1'b0;
            out_valid <= 1'b0;
            out_o     <= '0;
            out_ovf   <= '0;
        end else if (en) begin
            s1_valid  <= in_valid;
            out_valid <= s1_valid;
            if (s1_valid) begin
                out_o   <= lane_res;
                out_ovf <= lane_ovf;
            end
        end
    end

    // NOTE: operand registers carry no reset; they are only ever consumed behind s1_valid.
    always_ff @(posedge clk) begin
        if (en && in_valid) begin
            s1_op <= in_op;
            s1_a  <= in_a;
            s1_s  <= in_s;
        end
    end

    for (genvar i = 0; i < N; i++) begin : g_lane
        sfp_lane_op #(
            .W  (W),
            .QW (QW)
        ) u_lane (
            .op  (s1_op),
            .a   (s1_a[i]),
            .s   (s1_s),
            .res (lane_res[i]),
            .ovf (lane_ovf[i])
        );
    end

endmodule

// File: tb/tb_sfp_vec_scalar_op_pipe.sv
// Scoreboard bench: Q16.16 x3 directed instance plus a Q8.8 x4 random streaming instance.
module tb_sfp_vec_scalar_op_pipe;
    import sfp_pkg::*;

`ifdef SFP_VEC_SAT_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic             in0_valid, in0_ready, out0_valid, out0_ready;
    sfp_op_e          in0_op;
    logic [2:0][31:0] in0_a, out0_o;
    logic [31:0]      in0_s;
    logic [2:0]       out0_ovf;

    logic             in1_valid, in1_ready, out1_valid, out1_ready;
    sfp_op_e          in1_op;
    logic [3:0][15:0] in1_a, out1_o;
    logic [15:0]      in1_s;
    logic [3:0]       out1_ovf;

    int n_cmp = 0;
    int n_bad = 0;
    logic [98:0] q0[$];
    logic [67:0] q1[$];

    sfp_vec_scalar_op_pipe #(.N(3), .IW(16), .QW(16)) dut0 (
        .clk(clk), .rst(rst),
        .in_valid(in0_valid), .in_ready(in0_ready), .in_op(in0_op), .in_a(in0_a), .in_s(in0_s),
        .out_valid(out0_valid), .out_ready(out0_ready), .out_o(out0_o), .out_ovf(out0_ovf)
    );

    sfp_vec_scalar_op_pipe #(.N(4), .IW(8), .QW(8)) dut1 (
        .clk(clk), .rst(rst),
        .in_valid(in1_valid), .in_ready(in1_ready), .in_op(in1_op), .in_a(in1_a), .in_s(in1_s),
        .out_valid(out1_valid), .out_ready(out1_ready), .out_o(out1_o), .out_ovf(out1_ovf)
    );

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic longint sext(input logic [31:0] v, input int w);
        longint x;
        x = longint'(v);
        return (x << (64 - w)) >>> (64 - w);
    endfunction

    // Golden lane: exact integer arithmetic, then range test, then wrap or clamp.
    function automatic logic [32:0] lane_model(input int w, input int qw, input sfp_op_e op,
                                               input logic [31:0] a, input logic [31:0] s);
        longint x, y, r, mx, mn;
        logic [63:0] u;
        logic ovf;
        x = sext(a, w);
        y = sext(s, w);
        case (op)
            OP_ADD:  r = x + y;
            OP_SUB:  r = x - y;
            OP_RSUB: r = y - x;
            default: r = (x * y) >>> qw;
        endcase
        mx  = (longint'(1) <<< (w - 1)) - 1;
        mn  = -(longint'(1) <<< (w - 1));
        ovf = (r > mx) || (r < mn);
        if (SAT && ovf) r = (r > mx) ? mx : mn;
        u = 64'(r & ((longint'(1) <<< w) - 1));
        return {ovf, u[31:0]};
    endfunction

    function automatic logic [98:0] exp0(input sfp_op_e op, input logic [2:0][31:0] a, input logic [31:0] s);
        logic [2:0][31:0] o;
        logic [2:0] v;
        logic [32:0] l;
        for (int i = 0; i < 3; i++) begin
            l = lane_model(32, 16, op, a[i], s);
            o[i] = l[31:0];
            v[i] = l[32];
        end
        return {v, o};
    endfunction

    function automatic logic [67:0] exp1(input sfp_op_e op, input logic [3:0][15:0] a, input logic [15:0] s);
        logic [3:0][15:0] o;
        logic [3:0] v;
        logic [32:0] l;
        for (int i = 0; i < 4; i++) begin
            l = lane_model(16, 8, op, {16'h0, a[i]}, {16'h0, s});
            o[i] = l[15:0];
            v[i] = l[32];
        end
        return {v, o};
    endfunction

    function automatic logic [15:0] pick16();
        case ($urandom_range(0, 7))
            0:       return 16'h7FFF;
            1:       return 16'h8000;
            2:       return 16'h0100;
            default: return 16'($urandom);
        endcase
    endfunction

    // Present one beat on dut0 until accepted; optionally record its expected result.
    task automatic send0(input sfp_op_e op, input logic [31:0] a0, input logic [31:0] a1, input logic [31:0] a2,
                         input logic [31:0] s, input logic [31:0] e0, input logic [31:0] e1,
                         input logic [31:0] e2, input logic [2:0] eovf, input bit push);
        int  waitc = 0;
        bit  done  = 1'b0;
        in0_valid = 1'b1;
        in0_op    = op;
        in0_a[0]  = a0;
        in0_a[1]  = a1;
        in0_a[2]  = a2;
        in0_s     = s;
        while (!done) begin
            @(negedge clk);
            if (in0_ready) begin
                done = 1'b1;
                if (push) q0.push_back({eovf, e2, e1, e0});
            end else begin
                waitc++;
                if (waitc > 50) begin
                    check("in0_ready_timeout", in0_ready, 1'b1);
                    done = 1'b1;
                end
            end
            @(posedge clk);
            #1;
        end
        in0_valid = 1'b0;
    endtask

    always @(negedge clk) begin
        if (!rst && out0_valid && out0_ready) begin
            logic [98:0] e;
            check("sb0_has_entry", q0.size() != 0, 1'b1);
            if (q0.size() != 0) begin
                e = q0.pop_front();
                check("out0_o", out0_o, e[95:0]);
                check("out0_ovf", out0_ovf, e[98:96]);
            end
        end
    end

    always @(negedge clk) begin
        if (!rst && out1_valid && out1_ready) begin
            logic [67:0] e;
            check("sb1_has_entry", q1.size() != 0, 1'b1);
            if (q1.size() != 0) begin
                e = q1.pop_front();
                check("out1_o", out1_o, e[63:0]);
                check("out1_ovf", out1_ovf, e[67:64]);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [2:0][31:0] ta;
        logic [98:0]      e, e_first;
        int               idx, cyc, sent;

        rst = 1'b1;
        in0_valid = 1'b0; in0_op = OP_ADD; in0_a = '0; in0_s = '0; out0_ready = 1'b1;
        in1_valid = 1'b0; in1_op = OP_ADD; in1_a = '0; in1_s = '0; out1_ready = 1'b1;
        e_first = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", out0_valid, 1'b0);
        check("rst_out_o", out0_o, 96'h0);
        check("rst_out_ovf", out0_ovf, 3'b000);
        check("rst_out1_valid", out1_valid, 1'b0);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("post_rst_in_ready", in0_ready, 1'b1);

        // ADD and two-stage latency
        send0(OP_ADD, 32'h0001_0000, 32'h0002_0000, 32'hFFFF_0000, 32'h0000_8000,
              32'h0001_8000, 32'h0002_8000, 32'hFFFF_8000, 3'b000, 1'b1);
        check("lat_stage1", out0_valid, 1'b0);
        @(posedge clk);
        #1;
        check("lat_stage2", out0_valid, 1'b1);
        repeat (2) @(posedge clk);
        #1;

        // MUL with floor-toward-minus-infinity on the discarded fraction
        send0(OP_MUL, 32'h0002_0000, 32'hFFFF_8000, 32'h0000_0001, 32'h0001_8000,
              32'h0003_0000, 32'hFFFF_4000, 32'h0000_0001, 3'b000, 1'b1);
        send0(OP_MUL, 32'h0002_0000, 32'hFFFF_8000, 32'h0000_0001, 32'h0000_8000,
              32'h0001_0000, 32'hFFFF_C000, 32'h0000_0000, 3'b000, 1'b1);
        send0(OP_MUL, 32'h0002_0000, 32'hFFFF_8000, 32'hFFFF_FFFF, 32'h0000_8000,
              32'h0001_0000, 32'hFFFF_C000, 32'hFFFF_FFFF, 3'b000, 1'b1);

        // Overflow in both directions, wrap or clamp depending on build
        send0(OP_ADD, 32'h7FFF_0000, 32'h0000_0000, 32'hFFFF_0000, 32'h0001_0000,
              SAT ? 32'h7FFF_FFFF : 32'h8000_0000, 32'h0001_0000, 32'h0000_0000, 3'b001, 1'b1);
        send0(OP_RSUB, 32'h0001_0000, 32'h0000_0000, 32'hFFFF_FFFF, 32'h8000_0000,
              SAT ? 32'h8000_0000 : 32'h7FFF_0000, 32'h8000_0000, 32'h8000_0001, 3'b001, 1'b1);
        send0(OP_MUL, 32'h7FFF_0000, 32'h8000_0000, 32'h0001_0000, 32'h0002_0000,
              SAT ? 32'h7FFF_FFFF : 32'hFFFE_0000, SAT ? 32'h8000_0000 : 32'h0000_0000,
              32'h0002_0000, 3'b011, 1'b1);
        send0(OP_SUB, 32'h8000_0000, 32'h0003_0000, 32'h7FFF_FFFF, 32'h0001_0000,
              SAT ? 32'h8000_0000 : 32'h7FFF_0000, 32'h0002_0000, 32'h7FFE_FFFF, 3'b001, 1'b1);
        repeat (4) @(posedge clk);
        #1;
        check("directed_drained", q0.size(), 0);

        // Backpressure: out_ready low for three cycles while four beats stream in
        idx = 0;
        cyc = 0;
        while (idx < 4 && cyc < 40) begin
            for (int l = 0; l < 3; l++) ta[l] = 32'((idx * 4 + l + 1) << 16);
            in0_valid  = 1'b1;
            in0_op     = OP_ADD;
            in0_a      = ta;
            in0_s      = 32'h0000_8000;
            out0_ready = !(cyc >= 2 && cyc <= 4);
            e = exp0(OP_ADD, ta, 32'h0000_8000);
            if (idx == 0) e_first = e;
            @(negedge clk);
            if (cyc >= 2 && cyc <= 4) begin
                check("bp_in_ready", in0_ready, 1'b0);
                check("bp_out_valid", out0_valid, 1'b1);
                check("bp_hold_o", out0_o, e_first[95:0]);
            end
            if (in0_ready) begin
                q0.push_back(e);
                idx++;
            end
            @(posedge clk);
            #1;
            cyc++;
        end
        in0_valid  = 1'b0;
        out0_ready = 1'b1;
        check("bp_all_sent", idx, 4);
        repeat (6) @(posedge clk);
        #1;
        check("bp_drained", q0.size(), 0);

        // Reset with two beats in flight: both must vanish
        out0_ready = 1'b0;
        send0(OP_ADD, 32'h0005_0000, 32'h0006_0000, 32'h0007_0000, 32'h0001_0000,
              32'h0, 32'h0, 32'h0, 3'b000, 1'b0);
        send0(OP_SUB, 32'h0008_0000, 32'h0009_0000, 32'h000A_0000, 32'h0001_0000,
              32'h0, 32'h0, 32'h0, 3'b000, 1'b0);
        check("rf_pipe_loaded", out0_valid, 1'b1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("rf_out_valid", out0_valid, 1'b0);
        check("rf_out_o", out0_o, 96'h0);
        check("rf_out_ovf", out0_ovf, 3'b000);
        check("rf_in_ready", in0_ready, 1'b1);
        rst = 1'b0;
        out0_ready = 1'b1;
        repeat (4) begin
            @(posedge clk);
            #1;
            check("rf_no_stale", out0_valid, 1'b0);
        end

        // Random streaming on the Q8.8 x4 instance with random backpressure
        sent = 0;
        cyc  = 0;
        while (sent < 100 && cyc < 3000) begin
            in1_valid = ($urandom_range(0, 3) != 0);
            in1_op    = sfp_op_e'($urandom_range(0, 3));
            for (int l = 0; l < 4; l++) in1_a[l] = pick16();
            in1_s      = pick16();
            out1_ready = ($urandom_range(0, 2) != 0);
            @(negedge clk);
            if (in1_valid && in1_ready) begin
                q1.push_back(exp1(in1_op, in1_a, in1_s));
                sent++;
            end
            @(posedge clk);
            #1;
            cyc++;
        end
        in1_valid  = 1'b0;
        out1_ready = 1'b1;
        cyc = 0;
        while (q1.size() != 0 && cyc < 50) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        check("stream_sent", sent, 100);
        check("stream_drained", q1.size(), 0);
        check("final_q0_empty", q0.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
